// File: rtl/config_loader_pkg.sv
// ----------------------------------------------------------------------------
// config_loader_pkg
// Shared definitions for the configuration bitstream loader and for whatever
// computes the attached chain length at the top level.
//   BITS_PER_MUX4 : configuration bits consumed by one 4-input mux
//   state_t       : loader FSM state encoding (2-bit)
//   min_u         : unsigned minimum, used to size the final partial word
// ----------------------------------------------------------------------------
package config_loader_pkg;

    localparam int BITS_PER_MUX4 = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// ----------------------------------------------------------------------------
// config_loader_if
// Host-side word handshake into the configuration loader.
//   start      : one-cycle load request (host -> loader)
//   word_in    : bitstream word, bit 0 shifted first (host -> loader)
//   word_valid : word_in holds a valid word (host -> loader)
//   word_ready : loader accepts word_in this cycle (loader -> host)
// master = host side, slave = loader side.
// ----------------------------------------------------------------------------
interface config_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output start, output word_in, output word_valid, input word_ready);
    modport slave  (input start, input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/config_loader.sv
// ----------------------------------------------------------------------------
// config_loader
// Accepts configuration words from a host over valid/ready, serialises them
// LSB-first onto the configuration chain's serial input and gates the chain's
// shift enable. Pulses done once exactly CHAIN_LEN bits have been shifted.
// Ports:
//   config_clk  : single clock for loader and chain (rising edge)
//   reset       : asynchronous, active-high; abandons any load in progress
//   host        : start / word_in / word_valid / word_ready handshake
//   config_data : serial data to the first chain element's config_in
//   config_en   : shift enable to every chain element
//   busy        : high while fetching or shifting
//   done        : one-cycle pulse when the load has completed
// ----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 16
) (
    input  logic            config_clk,
    input  logic            reset,
    config_loader_if.slave  host,
    output logic            config_data,
    output logic            config_en,
    output logic            busy,
    output logic            done
);

    localparam int              CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam int unsigned      WORD_U  = WORD_W;

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_bits_left;
    logic [CNT_W-1:0]  w_fetch_cnt;
    logic              w_last_bit;

    // The final word may be partial: only the bits still owed to the chain
    // are shifted, the rest of that word is dropped.
    assign w_fetch_cnt = CNT_W'(min_u(WORD_U, 32'(r_bits_left)));
    assign w_last_bit  = (r_word_cnt == ONE_C);

    always_ff @(posedge config_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode only registered state, so the chain sees stable
    // config_en/config_data for the whole cycle.
    always_comb begin
        w_next          = r_state;
        host.word_ready = 1'b0;
        config_en       = 1'b0;
        config_data     = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (host.start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                host.word_ready = 1'b1;
                busy            = 1'b1;
                if (host.word_valid) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                config_en   = 1'b1;
                config_data = r_shreg[0];
                busy        = 1'b1;
                if (w_last_bit) begin
                    w_next = (r_bits_left == ONE_C) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge config_clk or posedge reset) begin
        if (reset) begin
            r_shreg     <= '0;
            r_word_cnt  <= '0;
            r_bits_left <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (host.start) r_bits_left <= LEN_C;
                end
                ST_FETCH: begin
                    if (host.word_valid) begin
                        r_shreg    <= host.word_in;
                        r_word_cnt <= w_fetch_cnt;
                    end
                end
                ST_SHIFT: begin
                    r_shreg     <= r_shreg >> 1;
                    r_word_cnt  <= r_word_cnt - ONE_C;
                    r_bits_left <= r_bits_left - ONE_C;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// ----------------------------------------------------------------------------
// tb_config_loader
// Drives two loaders (16-bit and 20-bit chains) and checks them against a
// bit-stream / timing reference derived from the word list, plus an emulated
// configuration chain that shifts whenever config_en is high.
// ----------------------------------------------------------------------------
module tb_config_loader;
    import config_loader_pkg::*;

    localparam int WORD_W = 8;
    localparam int LEN_A  = 8 * BITS_PER_MUX4;   // one WIDTH=2 switch box
    localparam int LEN_B  = 20;

    logic config_clk = 1'b0;
    logic reset;
    always #5 config_clk = ~config_clk;

    config_loader_if #(.WORD_W(WORD_W)) h16 ();
    config_loader_if #(.WORD_W(WORD_W)) h20 ();

    logic data16, en16, busy16, done16;
    logic data20, en20, busy20, done20;

    config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_A)) dut16 (
        .config_clk (config_clk),
        .reset      (reset),
        .host       (h16.slave),
        .config_data(data16),
        .config_en  (en16),
        .busy       (busy16),
        .done       (done16)
    );

    config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_B)) dut20 (
        .config_clk (config_clk),
        .reset      (reset),
        .host       (h20.slave),
        .config_data(data20),
        .config_en  (en20),
        .busy       (busy20),
        .done       (done20)
    );

    logic sel;   // 0 = 16-bit chain DUT, 1 = 20-bit chain DUT
    wire  w_en    = sel ? en20   : en16;
    wire  w_data  = sel ? data20 : data16;
    wire  w_busy  = sel ? busy20 : busy16;
    wire  w_done  = sel ? done20 : done16;
    wire  w_ready = sel ? h20.word_ready : h16.word_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   words [4];
    logic [31:0]  chain, chain_ref, exp_chain;
    logic [127:0] got_mask, exp_mask;
    int           en_cnt, hs_cnt, done_cnt, done_cyc, exp_done;
    bit           aborted;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic st, input logic vl, input logic [7:0] w);
        h16.start = 1'b0; h16.word_valid = 1'b0; h16.word_in = '0;
        h20.start = 1'b0; h20.word_valid = 1'b0; h20.word_in = '0;
        if (s) begin
            h20.start = st; h20.word_valid = vl; h20.word_in = w;
        end else begin
            h16.start = st; h16.word_valid = vl; h16.word_in = w;
        end
    endtask

    task automatic idle(input int nc);
        for (int i = 0; i < nc; i++) begin
            @(negedge config_clk);
            chk("idle_done", w_done, 0);
            chk("idle_busy", w_busy, 0);
            chk("idle_en", w_en, 0);
            chk("idle_ready", w_ready, 0);
        end
    endtask

    task automatic rand_words();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
    endtask

    // One load from start to done. stall_word: index of the word whose fetch
    // is stalled stall_len cycles (-1 = none). poke: pulse start mid-shift.
    // abort_at: assert reset once this many bits have been shifted (-1 = none).
    task automatic do_load(input bit s, input int stall_word, input int stall_len,
                           input bit poke, input int abort_at);
        int   n, c, rem, cnt, wi, cyc, bit_i, stall_left;
        bit   fin;
        logic st, vl;
        logic exp_bits [$];
        n = s ? LEN_B : LEN_A;
        sel = s;
        // Reference: the bit stream is the words' bits in order, LSB first,
        // truncated to the chain length; the first bit ends at the far end.
        exp_bits.delete();
        for (int k = 0; k < n; k++) exp_bits.push_back(words[k / WORD_W][k % WORD_W]);
        exp_chain = '0;
        for (int k = 0; k < n; k++) exp_chain[n - 1 - k] = exp_bits[k];
        // Reference timing: each word costs one fetch cycle (plus any stall)
        // then one shift cycle per bit; done follows the last shift.
        exp_mask = '0; c = 1; rem = n; wi = 0;
        while (rem > 0) begin
            c += 1 + ((wi == stall_word) ? stall_len : 0);
            cnt = (rem < WORD_W) ? rem : WORD_W;
            for (int k = 0; k < cnt; k++) exp_mask[c + k] = 1'b1;
            c += cnt; rem -= cnt; wi++;
        end
        exp_done = c;

        chain = '0; got_mask = '0; en_cnt = 0; hs_cnt = 0; done_cnt = 0;
        done_cyc = -1; aborted = 0; cyc = 0; bit_i = 0; stall_left = stall_len; fin = 0;
        @(negedge config_clk);
        drive(s, 1'b1, 1'b1, words[0]);
        while (!fin) begin
            @(negedge config_clk);
            cyc++;
            st = poke && (cyc == 5);
            if (w_ready && hs_cnt == stall_word && stall_left > 0) begin
                vl = 1'b0; stall_left--;
            end else begin
                vl = 1'b1;
            end
            drive(s, st, vl, words[(hs_cnt < 4) ? hs_cnt : 3]);
            if (w_ready) chk("ready_excludes_en", w_en, 0);
            if (w_en) begin
                chain = {chain[30:0], w_data};
                if (bit_i < n) chk("data_bit", w_data, exp_bits[bit_i]);
                else           chk("extra_shift_bits", bit_i, n - 1);
                bit_i++; en_cnt++; got_mask[cyc] = 1'b1;
            end
            if (w_ready && vl) hs_cnt++;
            if (w_done) begin
                done_cnt++; done_cyc = cyc; fin = 1;
                chk("busy_at_done", w_busy, 0);
            end else begin
                chk("busy_in_load", w_busy, 1);
            end
            if (abort_at >= 0 && bit_i == abort_at && w_en && !fin) begin
                #1 reset = 1'b1;
                #1;
                chk("abort_busy", w_busy, 0);
                chk("abort_en", w_en, 0);
                chk("abort_ready", w_ready, 0);
                chk("abort_data", w_data, 0);
                chk("abort_done", w_done, 0);
                @(negedge config_clk);
                reset = 1'b0;
                aborted = 1; fin = 1;
            end
            if (!fin && cyc > 100) begin
                chk("load_timeout", cyc, exp_done);
                fin = 1;
            end
        end
        drive(s, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_load(input string tag, input bit s);
        int n;
        n = s ? LEN_B : LEN_A;
        chk({tag, "_chain"}, chain & ((32'd1 << n) - 1), exp_chain);
        chk({tag, "_en_count"}, en_cnt, n);
        chk({tag, "_handshakes"}, hs_cnt, (n + WORD_W - 1) / WORD_W);
        chk({tag, "_en_cycles"}, got_mask, exp_mask);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        sel = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        #1;
        chk("rst_busy16", busy16, 0);
        chk("rst_en16", en16, 0);
        chk("rst_ready16", h16.word_ready, 0);
        chk("rst_data16", data16, 0);
        chk("rst_done16", done16, 0);
        chk("rst_busy20", busy20, 0);
        chk("rst_ready20", h20.word_ready, 0);
        repeat (2) @(negedge config_clk);
        reset = 1'b0;
        idle(2);

        // Directed: 0xA5, 0x3C on the 16-bit chain.
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h00; words[3] = 8'h00;
        do_load(1'b0, -1, 0, 1'b0, -1);
        check_load("a5_3c", 1'b0);
        chk("a5_3c_chain_lit", chain[15:0], 16'hA53C);
        chk("a5_3c_en_lit", got_mask, 128'h7FBFC);
        chk("a5_3c_done_lit", done_cyc, 19);
        chain_ref = chain;
        idle(3);

        // Partial final word on the 20-bit chain.
        words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hFF;
        do_load(1'b1, -1, 0, 1'b0, -1);
        check_load("len20", 1'b1);
        chk("len20_chain_lit", chain[19:0], 20'hFF00F);
        chk("len20_hs_lit", hs_cnt, 3);
        idle(3);

        // Host stall in the second fetch: same final chain as unstalled run.
        words[0] = 8'hA5; words[1] = 8'h3C;
        do_load(1'b0, 1, 5, 1'b0, -1);
        check_load("stall", 1'b0);
        chk("stall_same_chain", chain[15:0], chain_ref[15:0]);
        idle(3);

        // start during SHIFT is ignored: no second load follows.
        rand_words();
        do_load(1'b0, -1, 0, 1'b1, -1);
        check_load("poke", 1'b0);
        idle(6);

        // Reset mid-shift, then a fresh full load.
        rand_words();
        do_load(1'b0, -1, 0, 1'b0, 8);
        chk("abort_taken", aborted, 1);
        idle(2);
        rand_words();
        do_load(1'b0, -1, 0, 1'b0, -1);
        check_load("after_abort", 1'b0);

        // Back-to-back: start the cycle after done.
        rand_words();
        do_load(1'b0, -1, 0, 1'b0, -1);
        check_load("b2b_first", 1'b0);
        rand_words();
        do_load(1'b0, -1, 0, 1'b0, -1);
        check_load("b2b_second", 1'b0);
        idle(2);

        // Randomised loads with random stalls on either chain.
        for (int it = 0; it < 8; it++) begin
            rand_words();
            do_load(1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), 1'b0, -1);
            check_load("random", sel);
            idle(int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_loader.md
# config_loader

Bitstream loader that sits directly upstream of the fabric configuration chain (switch boxes, logic blocks and other programmable muxes daisy-chained through config_in/config_out). It accepts configuration words over a valid/ready handshake, serialises them LSB-first onto the chain's serial input, and gates the chain's shift enable. It signals completion once exactly CHAIN_LEN bits have been shifted.

## Interface
- WORD_W, 8, width of each bitstream word accepted from the host side
- CHAIN_LEN, 16, total configuration bits in the attached chain (2 per 4-input mux; 16 = one WIDTH=2 switch box); must be >= 1
- CNT_W (localparam), $clog2(CHAIN_LEN+1), width of the bit counter
- config_clk  input  1  single clock for loader and chain; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- word_in  input  WORD_W  bitstream word, bit 0 shifted first
- word_valid  input  1  word_in holds a valid word
- word_ready  output  1  loader accepts word_in this cycle
- config_data  output  1  serial data to the first element's config_in
- config_en  output  1  shift enable to every element's config_en
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when the load is complete

## Operation
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 goes to FETCH and clears bits_left to CHAIN_LEN. Otherwise stay.
- FETCH: word_ready=1. On word_valid&&word_ready, load word_in into shreg, set word_cnt=min(WORD_W, bits_left), go to SHIFT. Otherwise stay; config_en=0, so the chain holds.
- SHIFT: config_en=1, config_data=shreg[0]. Each cycle: shreg shifts right by 1, word_cnt and bits_left decrement. On the last bit of the word (word_cnt==1):
  - go to DONE if bits_left==1;
  - otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Final partial word: if bits_left < WORD_W at fetch, only the low bits_left bits are shifted. The upper bits are discarded and no extra word is requested.
- Bit ordering: the first bit shifted (word 0, bit 0) ends in the far end of the chain, nearest the chain's final config_out.
- start while not in IDLE is ignored; there is no queueing.
- word_valid in IDLE, SHIFT or DONE is ignored because word_ready=0.
- busy=1 in FETCH and SHIFT; busy=0 in IDLE and DONE.

## Timing
- Reset values: state=IDLE, word_ready=0, config_en=0, config_data=0, busy=0, done=0, shreg=0, counters=0.
- Reset asserted mid-load: outputs take their reset values asynchronously and the load is abandoned. Chain contents are then undefined and a full reload is required.
- config_data and config_en are driven only from registered state (no combinational path from inputs), so they are stable for the whole cycle. The chain samples them at the same rising edge on which the loader advances.
- Latency with word_valid held high: start accepted at edge 0; FETCH in cycle 1; each word costs 1 FETCH cycle plus word_cnt SHIFT cycles; done follows 1 cycle after the last SHIFT.
- Total load time with word_valid held high = 1 + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN cycles after start, then the done pulse.
- config_en is high for exactly CHAIN_LEN cycles per load. Host stalls only insert config_en=0 cycles.
- There is no overlap between FETCH and SHIFT; word_ready is never high while config_en is high.

## Structure
- Shared package/include config_defs: BITS_PER_MUX4 = 2 and the FSM state encodings (2-bit), so that top-level chain-length computation and the loader agree.
- Single module, no sub-modules; the shift register and counters are inline.

## Test plan
- CHAIN_LEN=16, WORD_W=8, words 0xA5 then 0x3C with word_valid always high:
  - config_en is high in cycles 2-9 and 11-18;
  - config_data sequence is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0;
  - done pulses in cycle 19;
  - a 16-bit model shift register matches.
- CHAIN_LEN=20, WORD_W=8, words 0xFF, 0x00, 0xFF:
  - the third word shifts only 4 ones;
  - exactly 3 handshakes occur;
  - config_en high count = 20.
- Host stall: word_valid held low for 5 cycles in the second FETCH -> config_en=0 and chain contents unchanged during the stall; the final chain value is identical to the unstalled run.
- start pulsed during SHIFT -> ignored; exactly one done pulse per accepted start.
- reset asserted in the middle of SHIFT (bit 7 of 16):
  - immediately busy=0, config_en=0, word_ready=0;
  - a fresh start then completes a full 16-bit load correctly.
- Back-to-back loads: start asserted the cycle after done -> second load is accepted, with 16 more config_en cycles.
